// File: rtl/booth_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_ctrl
// Brief    : Sequential radix-4 Booth multiplier controller, signed
//            WIDTH x WIDTH -> 2*WIDTH. Optional performance counters are
//            enabled by defining BOOTH_MUL_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module booth_mul_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 op_busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
`ifdef BOOTH_MUL_PERF_CNT_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [15:0]          perf_abort
`endif
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER + 1);
    localparam int AW   = WIDTH + 2;
    localparam logic [CW-1:0] c_last_step = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic [AW-1:0]           r_acc;
    logic [AW-1:0]           r_m;
    logic [WIDTH-1:0]        r_q;
    logic                    r_q_prev;
    logic                    r_busy;
    logic                    r_done;
    logic [2*WIDTH-1:0]      r_result;

    logic [2:0]              w_triple;
    logic [AW-1:0]           w_m2;
    logic [AW-1:0]           w_addend;
    logic [AW-1:0]           w_sum;
    logic signed [AW+WIDTH-1:0] w_pair;
    logic                    w_last;

    assign w_triple = {r_q[1:0], r_q_prev};
    assign w_m2     = {r_m[AW-2:0], 1'b0};

    always_comb begin
        w_addend = '0;
        case (w_triple)
            3'b001, 3'b010: w_addend = r_m;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = ~w_m2 + AW'(1);
            3'b101, 3'b110: w_addend = ~r_m + AW'(1);
            default:        w_addend = '0;
        endcase
    end

    assign w_sum  = r_acc + w_addend;
    // The extra two accumulator bits keep +-2M and min*min exact through the shift.
    assign w_pair = $signed({w_sum, r_q}) >>> 2;
    assign w_last = (r_cnt == c_last_step);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_q_prev <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else if (op_clear) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        r_state  <= S_EXEC;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_m      <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                        r_q      <= multiplier;
                        r_q_prev <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_acc    <= w_pair[AW+WIDTH-1:WIDTH];
                    r_q      <= w_pair[WIDTH-1:0];
                    r_q_prev <= r_q[1];
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_pair[2*WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign op_busy = r_busy;
    assign op_done = r_done;
    assign result  = r_result;

`ifdef BOOTH_MUL_PERF_CNT_EN
    logic [31:0] r_perf_ops;
    logic [15:0] r_perf_abort;

    // Saturating counters; op_clear does not touch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_ops   <= '0;
            r_perf_abort <= '0;
        end else if (r_state == S_EXEC) begin
            if (op_clear) begin
                if (r_perf_abort != '1) r_perf_abort <= r_perf_abort + 16'd1;
            end else if (w_last) begin
                if (r_perf_ops != '1) r_perf_ops <= r_perf_ops + 32'd1;
            end
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_abort = r_perf_abort;
`endif

endmodule
`default_nettype wire

// File: tb/tb_booth_mul_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_ctrl
// Brief    : Directed self-checking bench for booth_mul_ctrl (WIDTH=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_mul_ctrl;

    localparam int WIDTH = 64;

    logic                clk;
    logic                reset;
    logic                op_start;
    logic                op_clear;
    logic [WIDTH-1:0]    multiplicand;
    logic [WIDTH-1:0]    multiplier;
    logic                op_busy;
    logic                op_done;
    logic [2*WIDTH-1:0]  result;
`ifdef BOOTH_MUL_PERF_CNT_EN
    logic [31:0]         perf_ops;
    logic [15:0]         perf_abort;
`endif

    int errors = 0;
    int checks = 0;

    booth_mul_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_busy      (op_busy),
        .op_done      (op_done),
        .result       (result)
`ifdef BOOTH_MUL_PERF_CNT_EN
        ,
        .perf_ops     (perf_ops),
        .perf_abort   (perf_abort)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation, count busy cycles, check result, hold, then clear.
    task automatic run_op(input string tag, input logic [63:0] m, input logic [63:0] q,
                          input logic [127:0] exp, input int glitch);
        int n;
        multiplicand = m;
        multiplier   = q;
        op_start     = 1'b1;
        step();
        op_start     = 1'b0;
        multiplicand = {$urandom, $urandom};
        multiplier   = {$urandom, $urandom};
        chk({tag, " busy_first"}, 128'(op_busy), 128'd1);
        chk({tag, " result_in_exec"}, result, 128'd0);
        n = 1;
        while (op_busy === 1'b1 && n < 100) begin
            op_start = (n == glitch);
            step();
            if (op_busy === 1'b1) n++;
        end
        op_start = 1'b0;
        chk({tag, " busy_cycles"}, 128'(n), 128'd32);
        chk({tag, " done"}, 128'(op_done), 128'd1);
        chk({tag, " result"}, result, exp);
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        step();
        chk({tag, " done_hold"}, 128'(op_done), 128'd1);
        chk({tag, " result_hold"}, result, exp);
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        chk({tag, " done_after_clear"}, 128'(op_done), 128'd0);
        chk({tag, " result_after_clear"}, result, 128'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        chk("rst busy", 128'(op_busy), 128'd0);
        chk("rst done", 128'(op_done), 128'd0);
        chk("rst result", result, 128'd0);
`ifdef BOOTH_MUL_PERF_CNT_EN
        chk("rst perf_ops", 128'(perf_ops), 128'd0);
        chk("rst perf_abort", 128'(perf_abort), 128'd0);
`endif
        reset = 1'b0;
        step();
    endtask

    initial begin
        reset        = 1'b1;
        op_start     = 1'b0;
        op_clear     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        do_reset();

        run_op("3x5", 64'd3, 64'd5, 128'h0F, 0);
        run_op("m1xm1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'h01, 0);
        run_op("m7x6", 64'hFFFF_FFFF_FFFF_FFF9, 64'd6,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6, 0);
        run_op("maxxmin", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
               128'hC000_0000_0000_0000_8000_0000_0000_0000, 0);
        run_op("minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               128'h4000_0000_0000_0000_0000_0000_0000_0000, 0);
        run_op("maxxmax", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
               128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 0);
        run_op("0xm", 64'd0, 64'h1234_5678_9ABC_DEF0, 128'd0, 0);
        run_op("start_in_exec", 64'd3, 64'd5, 128'h0F, 7);

        // Abort at busy cycle 10.
        multiplicand = 64'd11;
        multiplier   = 64'd13;
        op_start     = 1'b1;
        step();
        op_start     = 1'b0;
        repeat (9) step();
        chk("abort pre busy", 128'(op_busy), 128'd1);
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        chk("abort busy", 128'(op_busy), 128'd0);
        chk("abort done", 128'(op_done), 128'd0);
        chk("abort result", result, 128'd0);
        repeat (40) step();
        chk("abort stays idle", 128'(op_busy | op_done), 128'd0);

        // Start and clear together in IDLE.
        op_start = 1'b1;
        op_clear = 1'b1;
        step();
        op_start = 1'b0;
        op_clear = 1'b0;
        chk("start+clear busy", 128'(op_busy), 128'd0);
        repeat (40) step();
        chk("start+clear done", 128'(op_done), 128'd0);

        // Async reset between edges mid-EXEC.
        multiplicand = 64'd3;
        multiplier   = 64'd5;
        op_start     = 1'b1;
        step();
        op_start     = 1'b0;
        repeat (5) step();
        #2;
        reset = 1'b1;
        #1;
        chk("async exec busy", 128'(op_busy), 128'd0);
        chk("async exec done", 128'(op_done), 128'd0);
        reset = 1'b0;
        step();

        // Async reset between edges while DONE.
        op_start = 1'b1;
        step();
        op_start = 1'b0;
        repeat (40) step();
        chk("pre async done", 128'(op_done), 128'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async done done", 128'(op_done), 128'd0);
        chk("async done result", result, 128'd0);
        reset = 1'b0;
        step();

        // Recovery plus counter bookkeeping: 3 completed ops and 1 abort.
        do_reset();
        run_op("perf a", 64'd2, 64'd9, 128'd18, 0);
        run_op("perf b", 64'hFFFF_FFFF_FFFF_FFFE, 64'd9,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEE, 0);
        multiplicand = 64'd1;
        multiplier   = 64'd1;
        op_start     = 1'b1;
        step();
        op_start     = 1'b0;
        repeat (3) step();
        op_clear = 1'b1;
        step();
        op_clear = 1'b0;
        chk("perf abort busy", 128'(op_busy), 128'd0);
        run_op("perf c", 64'd100, 64'hFFFF_FFFF_FFFF_FF9C,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_D8F0, 0);
`ifdef BOOTH_MUL_PERF_CNT_EN
        chk("perf_ops", 128'(perf_ops), 128'd3);
        chk("perf_abort", 128'(perf_abort), 128'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
